// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Bundle between the pipeline datapath and the hazard/shared-memory controller.
//   master : pipeline side - drives hazard sources, receives hold/flush/grant
//   slave  : hazard_ctrl side
// Hazard sources : mem_req, exe_mem_read, exe_reg_write, exe_reg_addr,
//                  id_rs1/id_rs2 (+ _used), branch_taken
// Controls       : pc_hold, pc_load, if_id_hold/flush, id_exe_hold/flush,
//                  exe_mem_hold, mem_grant (0 = IF, 1 = MEM), stall_count
// -----------------------------------------------------------------------------
interface hazard_ctrl_if #(
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
);
    logic              mem_req;
    logic              exe_mem_read;
    logic              exe_reg_write;
    logic [REG_AW-1:0] exe_reg_addr;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic              branch_taken;

    logic              pc_hold;
    logic              pc_load;
    logic              if_id_hold;
    logic              if_id_flush;
    logic              id_exe_hold;
    logic              id_exe_flush;
    logic              exe_mem_hold;
    logic              mem_grant;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output mem_req, exe_mem_read, exe_reg_write, exe_reg_addr,
               id_rs1, id_rs2, id_rs1_used, id_rs2_used, branch_taken,
        input  pc_hold, pc_load, if_id_hold, if_id_flush, id_exe_hold,
               id_exe_flush, exe_mem_hold, mem_grant, stall_count
    );

    modport slave (
        input  mem_req, exe_mem_read, exe_reg_write, exe_reg_addr,
               id_rs1, id_rs2, id_rs1_used, id_rs2_used, branch_taken,
        output pc_hold, pc_load, if_id_hold, if_id_flush, id_exe_hold,
               id_exe_flush, exe_mem_hold, mem_grant, stall_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Hazard and shared-SRAM controller for the 5-stage 16-bit pipeline.
// Resolves, in priority order: structural (multi-cycle SRAM access held by the
// MEM stage), taken branch, load-use. Control outputs are Mealy (combinational
// from state, counter and inputs); stall_count is registered.
// Ports:
//   clk  - pipeline clock
//   rst  - asynchronous, active-low reset
//   hz   - hazard_ctrl_if.slave (hazard sources in, stage controls out)
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int REG_AW     = 4,
    parameter int MEM_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MEM  = 1'b1
    } state_e;

    // The first access cycle is spent in IDLE, the last one is the release
    // cycle, so MEM counts down the cycles strictly in between.
    localparam int         CNT_INIT_I = (MEM_CYCLES > 1) ? (MEM_CYCLES - 2) : 0;
    localparam logic [3:0] CNT_INIT   = CNT_INIT_I[3:0];

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic [REG_AW-1:0] exe_addr_s;
    logic load_use_s;
    logic full_hold_s;
    logic release_s;
    logic pc_hold_s, pc_load_s, if_id_hold_s, if_id_flush_s;
    logic id_exe_hold_s, id_exe_flush_s, exe_mem_hold_s, mem_grant_s;

    assign exe_addr_s = hz.exe_reg_addr;

    // Load-use detection; register 0 is treated like any other register.
    always_comb begin
        load_use_s = hz.exe_mem_read & hz.exe_reg_write &
                     ((hz.id_rs1_used & (hz.id_rs1 == exe_addr_s)) |
                      (hz.id_rs2_used & (hz.id_rs2 == exe_addr_s)));
    end

    // Next-state, counter and Mealy control outputs.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        full_hold_s    = 1'b0;
        release_s      = 1'b0;
        mem_grant_s    = 1'b0;
        pc_hold_s      = 1'b0;
        pc_load_s      = 1'b0;
        if_id_hold_s   = 1'b0;
        if_id_flush_s  = 1'b0;
        id_exe_hold_s  = 1'b0;
        id_exe_flush_s = 1'b0;
        exe_mem_hold_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hz.mem_req) begin
                    mem_grant_s = 1'b1;
                    if (MEM_CYCLES == 1) begin
                        release_s = 1'b1;
                    end else begin
                        full_hold_s = 1'b1;
                        state_d     = ST_MEM;
                        cnt_d       = CNT_INIT;
                    end
                end else begin
                    mem_grant_s = 1'b0;
                end
            end
            ST_MEM: begin
                mem_grant_s = 1'b1;
                if (cnt_q != 4'd0) begin
                    full_hold_s = 1'b1;
                    cnt_d       = cnt_q - 4'd1;
                end else begin
                    release_s = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        // While SRAM is busy EXE is frozen, so branch/load-use simply
        // re-present at the release cycle and need no latching.
        if (full_hold_s) begin
            pc_hold_s      = 1'b1;
            if_id_hold_s   = 1'b1;
            id_exe_hold_s  = 1'b1;
            exe_mem_hold_s = 1'b1;
        end else if (hz.branch_taken) begin
            pc_load_s      = 1'b1;
            if_id_flush_s  = 1'b1;
            id_exe_flush_s = 1'b1;
        end else if (load_use_s) begin
            // IF/ID is held (not flushed) so no fetched instruction is lost.
            pc_hold_s      = 1'b1;
            if_id_hold_s   = 1'b1;
            id_exe_flush_s = 1'b1;
        end else if (release_s) begin
            // MEM consumed this cycle's fetch slot: refetch, bubble IF/ID.
            pc_hold_s      = 1'b1;
            if_id_flush_s  = 1'b1;
        end else begin
            pc_hold_s      = 1'b0;
        end

        if (!rst) begin
            mem_grant_s    = 1'b0;
            pc_hold_s      = 1'b0;
            pc_load_s      = 1'b0;
            if_id_hold_s   = 1'b0;
            if_id_flush_s  = 1'b1;
            id_exe_hold_s  = 1'b0;
            id_exe_flush_s = 1'b1;
            exe_mem_hold_s = 1'b0;
        end else begin
            mem_grant_s    = mem_grant_s;
        end
    end

    // Stall performance counter: counts cycles where the PC is held.
    always_comb begin
        if (pc_hold_s && !pc_load_s) begin
            stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // State, access counter and stall counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 4'd0;
            stall_count_q <= {CNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign hz.pc_hold      = pc_hold_s;
    assign hz.pc_load      = pc_load_s;
    assign hz.if_id_hold   = if_id_hold_s;
    assign hz.if_id_flush  = if_id_flush_s;
    assign hz.id_exe_hold  = id_exe_hold_s;
    assign hz.id_exe_flush = id_exe_flush_s;
    assign hz.exe_mem_hold = exe_mem_hold_s;
    assign hz.mem_grant    = mem_grant_s;
    assign hz.stall_count  = stall_count_q;

endmodule
